// File: rtl/cnt_pkg.sv
// ---------------------------------------------------------------------------
// cnt_pkg
// Shared definitions for the parametrised up/down counter.
//   - mode encodings driven on the counter's 'mode' input
//   - run/done state encoding for the one-shot FSM
// ---------------------------------------------------------------------------
package cnt_pkg;

  // Counting behaviour at the terminal value; 2'b11 is treated as WRAP.
  localparam logic [1:0] MODE_WRAP    = 2'b00;
  localparam logic [1:0] MODE_SAT     = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;

  // RUN accepts steps; DONE is entered after a one-shot terminal step and
  // ignores steps until a load or reset.
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } cnt_state_e;

endpackage

// File: rtl/cnt_prescaler.sv
// ---------------------------------------------------------------------------
// cnt_prescaler
// Step divider for param_updown_counter. Counts cycles in which t=1 and
// raises en_tick on the cycle the count equals 'prescale', returning to 0
// on that cycle, so the counter steps once every prescale+1 enabled cycles.
// Only instantiated when CNT_PRESCALE_EN is defined.
// Ports:
//   clk      in  rising-edge clock
//   reset    in  synchronous, active-low reset
//   t        in  count enable from the counter
//   clr      in  synchronous clear (driven by the counter's load strobe)
//   prescale in  divider value (PRESCALE_W bits)
//   en_tick  out step permission for the current cycle (combinational)
// ---------------------------------------------------------------------------
module cnt_prescaler #(
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  t,
  input  logic                  clr,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  en_tick
);

  logic [PRESCALE_W-1:0] cnt_q;
  logic [PRESCALE_W-1:0] cnt_d;

  // en_tick looks at the current count so the tick lands in the same cycle
  // as the t that completes the period. If prescale is lowered below the
  // current count, the count runs through its natural wrap before matching.
  always_comb begin
    en_tick = (cnt_q == prescale);
    cnt_d   = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (t) begin
      cnt_d = en_tick ? '0 : cnt_q + PRESCALE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/param_updown_counter.sv
// ---------------------------------------------------------------------------
// param_updown_counter
// Synchronous parametrised up/down counter with programmable modulus,
// wrap / saturate / one-shot terminal behaviour, parallel load, one-cycle
// terminal-count pulse and sticky overflow flag.
// Optional feature macro: CNT_PRESCALE_EN (adds 'prescale' port and a step
// divider; without it every cycle with t=1 is a step).
// Ports:
//   clk      in  rising-edge clock
//   reset    in  synchronous, active-low reset
//   t        in  count enable (step request)
//   up_dn    in  1 = up, 0 = down
//   mode     in  00 WRAP, 01 SAT, 10 ONESHOT, 11 WRAP
//   load     in  parallel load strobe (wins over a step)
//   load_val in  value to load, clamped to MODULUS-1
//   clr_ovf  in  clear sticky overflow (a same-cycle set wins)
//   prescale in  step divider (only with CNT_PRESCALE_EN)
//   q        out registered count value
//   tc       out terminal-count pulse, aligned with the q update
//   ovf      out sticky overflow flag
// ---------------------------------------------------------------------------
module param_updown_counter
  import cnt_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int MODULUS    = 256,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  t,
  input  logic                  up_dn,
  input  logic [1:0]            mode,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic                  clr_ovf,
`ifdef CNT_PRESCALE_EN
  input  logic [PRESCALE_W-1:0] prescale,
`endif
  output logic [WIDTH-1:0]      q,
  output logic                  tc,
  output logic                  ovf
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  cnt_state_e       state_q, state_d;

  logic en_tick;
  logic step;
  logic at_term;

`ifdef CNT_PRESCALE_EN
  // A load restarts a full prescale period.
  cnt_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .t        (t),
    .clr      (load),
    .prescale (prescale),
    .en_tick  (en_tick)
  );
`else
  // Keeps PRESCALE_W referenced so both builds share one parameter list.
  logic [PRESCALE_W-1:0] unused_prescale_w;
  assign unused_prescale_w = '0;
  assign en_tick           = 1'b1;
`endif

  // Next-state logic: load beats step, step beats hold. Terminal value
  // depends on direction; terminal steps always pulse tc and set ovf, and
  // the mode only decides where q goes. clr_ovf is applied first so a
  // same-cycle overflow set overrides it.
  always_comb begin
    q_d     = q_q;
    tc_d    = 1'b0;
    ovf_d   = ovf_q;
    state_d = state_q;
    at_term = up_dn ? (q_q == MAX_VAL) : (q_q == '0);
    step    = t && en_tick && (state_q == ST_RUN);

    if (clr_ovf) begin
      ovf_d = 1'b0;
    end

    if (load) begin
      q_d     = (load_val > MAX_VAL) ? MAX_VAL : load_val;
      state_d = ST_RUN;
    end else if (step) begin
      if (at_term) begin
        tc_d  = 1'b1;
        ovf_d = 1'b1;
        case (mode)
          MODE_SAT:     q_d = q_q;
          MODE_ONESHOT: state_d = ST_DONE;
          default:      q_d = up_dn ? '0 : MAX_VAL;
        endcase
      end else begin
        q_d = up_dn ? q_q + WIDTH'(1) : q_q - WIDTH'(1);
      end
    end
  end

  // All state on one edge; reset only acts when sampled at that edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      q_q     <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
      state_q <= ST_RUN;
    end else begin
      q_q     <= q_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
      state_q <= state_d;
    end
  end

  assign q   = q_q;
  assign tc  = tc_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_param_updown_counter.sv
// ---------------------------------------------------------------------------
// tb_param_updown_counter
// Directed bench for param_updown_counter with WIDTH=8, MODULUS=10.
// Stimulus queues the expected post-edge {q, tc, ovf}; a monitor pops and
// compares one entry shortly after every rising edge.
// ---------------------------------------------------------------------------
module tb_param_updown_counter;
  import cnt_pkg::*;

  localparam int WIDTH   = 8;
  localparam int MODULUS = 10;
  localparam int PRE_W   = 4;

  typedef struct {
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             ovf;
    string            name;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             t;
  logic             up_dn;
  logic [1:0]       mode;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             clr_ovf;
`ifdef CNT_PRESCALE_EN
  logic [PRE_W-1:0] prescale;
`endif
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             ovf;

  exp_t exp_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  param_updown_counter #(
    .WIDTH      (WIDTH),
    .MODULUS    (MODULUS),
    .PRESCALE_W (PRE_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .t        (t),
    .up_dn    (up_dn),
    .mode     (mode),
    .load     (load),
    .load_val (load_val),
    .clr_ovf  (clr_ovf),
`ifdef CNT_PRESCALE_EN
    .prescale (prescale),
`endif
    .q        (q),
    .tc       (tc),
    .ovf      (ovf)
  );

  // 10 ns clock period
  always #5 clk = ~clk;

  // Compares the live DUT outputs against one expected triple.
  task automatic checkOutput(input string name, input logic [WIDTH-1:0] e_q,
                             input logic e_tc, input logic e_ovf);
    tests_run++;
    if (q !== e_q || tc !== e_tc || ovf !== e_ovf) begin
      tests_failed++;
      $display("[TB] FAIL %s: got q=%0d tc=%0b ovf=%0b, expected q=%0d tc=%0b ovf=%0b",
               name, q, tc, ovf, e_q, e_tc, e_ovf);
    end
  endtask

  // Drives one cycle of inputs at the falling edge, queues the expected
  // outputs after the next rising edge, then waits for that edge.
  task automatic applyStimulus(input logic rst_n, input logic t_i, input logic up_i,
                               input logic [1:0] mode_i, input logic load_i,
                               input logic [WIDTH-1:0] lval_i, input logic clr_i,
                               input logic [WIDTH-1:0] e_q, input logic e_tc,
                               input logic e_ovf, input string name);
    exp_t e;
    @(negedge clk);
    reset    = rst_n;
    t        = t_i;
    up_dn    = up_i;
    mode     = mode_i;
    load     = load_i;
    load_val = lval_i;
    clr_ovf  = clr_i;
    e.q = e_q; e.tc = e_tc; e.ovf = e_ovf; e.name = name;
    exp_q.push_back(e);
    @(posedge clk);
  endtask

  // Monitor: one expectation per edge, sampled 1 ns after the edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput(e.name, e.q, e.tc, e.ovf);
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    reset = 1'b0; t = 1'b0; up_dn = 1'b1; mode = MODE_WRAP;
    load = 1'b0; load_val = '0; clr_ovf = 1'b0;
`ifdef CNT_PRESCALE_EN
    prescale = '0;
`endif

    // 1. reset with t=1 for two edges, then wrap up through 0..9,0
    applyStimulus(0, 1, 1, MODE_WRAP, 0, 0, 0, 0, 0, 0, "t1_reset_a");
    applyStimulus(0, 1, 1, MODE_WRAP, 0, 0, 0, 0, 0, 0, "t1_reset_b");
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(1, 1, 1, MODE_WRAP, 0, 0, 0, WIDTH'(i % 10),
                    (i == 10), (i == 10), "t1_wrap_up");
    end
    applyStimulus(1, 0, 1, MODE_WRAP, 0, 0, 0, 0, 0, 1, "t1_hold");

    // 2. load 3, count down saturating at 0, then clear overflow
    applyStimulus(1, 0, 0, MODE_SAT, 1, 3, 0, 3, 0, 1, "t2_load3");
    applyStimulus(1, 1, 0, MODE_SAT, 0, 0, 0, 2, 0, 1, "t2_dn2");
    applyStimulus(1, 1, 0, MODE_SAT, 0, 0, 0, 1, 0, 1, "t2_dn1");
    applyStimulus(1, 1, 0, MODE_SAT, 0, 0, 0, 0, 0, 1, "t2_dn0");
    applyStimulus(1, 1, 0, MODE_SAT, 0, 0, 0, 0, 1, 1, "t2_sat_a");
    applyStimulus(1, 1, 0, MODE_SAT, 0, 0, 0, 0, 1, 1, "t2_sat_b");
    applyStimulus(1, 0, 0, MODE_SAT, 0, 0, 1, 0, 0, 0, "t2_clr_ovf");

    // 3. one-shot from 7, DONE ignores steps, load re-arms
    applyStimulus(1, 0, 1, MODE_ONESHOT, 1, 7, 0, 7, 0, 0, "t3_load7");
    applyStimulus(1, 1, 1, MODE_ONESHOT, 0, 0, 0, 8, 0, 0, "t3_up8");
    applyStimulus(1, 1, 1, MODE_ONESHOT, 0, 0, 0, 9, 0, 0, "t3_up9");
    applyStimulus(1, 1, 1, MODE_ONESHOT, 0, 0, 0, 9, 1, 1, "t3_term");
    applyStimulus(1, 1, 1, MODE_ONESHOT, 0, 0, 0, 9, 0, 1, "t3_done_a");
    applyStimulus(1, 1, 1, MODE_ONESHOT, 0, 0, 0, 9, 0, 1, "t3_done_b");
    applyStimulus(1, 0, 1, MODE_ONESHOT, 1, 2, 0, 2, 0, 1, "t3_reload2");
    applyStimulus(1, 1, 1, MODE_ONESHOT, 0, 0, 0, 3, 0, 1, "t3_resume");

    // 4. clamp, load beats step, overflow set beats clear
    applyStimulus(1, 0, 1, MODE_WRAP, 0, 0, 1, 3, 0, 0, "t4_clr");
    applyStimulus(1, 0, 1, MODE_WRAP, 1, 15, 0, 9, 0, 0, "t4_clamp15");
    applyStimulus(1, 1, 1, MODE_WRAP, 1, 4, 0, 4, 0, 0, "t4_load_vs_t");
    applyStimulus(1, 0, 1, MODE_WRAP, 1, 9, 0, 9, 0, 0, "t4_load9");
    applyStimulus(1, 1, 1, MODE_WRAP, 0, 0, 1, 0, 1, 1, "t4_set_wins");
    applyStimulus(1, 0, 1, MODE_WRAP, 0, 0, 0, 0, 0, 1, "t4_after");
    applyStimulus(1, 1, 0, 2'b11, 0, 0, 0, 9, 1, 1, "t4_mode11_wrap_dn");

    // 5. synchronous reset while counting at 5
    applyStimulus(1, 0, 1, MODE_WRAP, 1, 4, 0, 4, 0, 1, "t5_load4");
    applyStimulus(1, 1, 1, MODE_WRAP, 0, 0, 0, 5, 0, 1, "t5_up5");
    begin
      exp_t e;
      @(negedge clk);
      reset = 1'b0;
      t     = 1'b1;
      #1;
      checkOutput("t5_reset_pending", 5, 0, 1);
      e.q = 0; e.tc = 0; e.ovf = 0; e.name = "t5_reset_edge";
      exp_q.push_back(e);
      @(posedge clk);
    end
    applyStimulus(1, 1, 1, MODE_WRAP, 0, 0, 0, 1, 0, 0, "t5_resume1");
    applyStimulus(1, 1, 1, MODE_WRAP, 0, 0, 0, 2, 0, 0, "t5_resume2");

`ifdef CNT_PRESCALE_EN
    // 6. prescale=2: one step per three enabled cycles; load restarts period
    prescale = 4'd2;
    applyStimulus(1, 0, 1, MODE_WRAP, 1, 0, 0, 0, 0, 0, "t6_load0");
    applyStimulus(1, 1, 1, MODE_WRAP, 0, 0, 0, 0, 0, 0, "t6_p1");
    applyStimulus(1, 1, 1, MODE_WRAP, 0, 0, 0, 0, 0, 0, "t6_p2");
    applyStimulus(1, 1, 1, MODE_WRAP, 0, 0, 0, 1, 0, 0, "t6_p3");
    applyStimulus(1, 1, 1, MODE_WRAP, 0, 0, 0, 1, 0, 0, "t6_p4");
    applyStimulus(1, 1, 1, MODE_WRAP, 0, 0, 0, 1, 0, 0, "t6_p5");
    applyStimulus(1, 1, 1, MODE_WRAP, 0, 0, 0, 2, 0, 0, "t6_p6");
    applyStimulus(1, 1, 1, MODE_WRAP, 0, 0, 0, 2, 0, 0, "t6_mid");
    applyStimulus(1, 1, 1, MODE_WRAP, 1, 5, 0, 5, 0, 0, "t6_load5");
    applyStimulus(1, 1, 1, MODE_WRAP, 0, 0, 0, 5, 0, 0, "t6_r1");
    applyStimulus(1, 1, 1, MODE_WRAP, 0, 0, 0, 5, 0, 0, "t6_r2");
    applyStimulus(1, 1, 1, MODE_WRAP, 0, 0, 0, 6, 0, 0, "t6_r3");
`endif

    // Drain: the monitor must have consumed every expectation.
    @(negedge clk);
    t = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
